fairy_sram_arbiter: RTL and testbench

- Shares the single synchronous data SRAM port between two requesters: the instruction-fetch stage (reads only) and the memory stage (loads and byte/half/word stores).
- The SRAM has a fixed 1-cycle read latency.
- Data accesses have priority. A starvation counter guarantees fetch progress.
- Registered return tracking routes read data to the requester that was granted.
- Sits between the pipeline stages and the SRAM macro; the pipeline uses the grants as stall conditions.

---
 rtl/fairy_sram_arbiter.sv | 86 ++++++++
 tb/tb_fairy_sram_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fairy_sram_arbiter.sv
// Arbitrates the single data SRAM port between instruction fetch and the memory
// stage: data wins by default, a starvation counter forces fetch through.
module fairy_sram_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned AW         = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          dm_req,
  input  logic          dm_wr,
  input  logic [3:0]    dm_be,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [31:0]   dm_rdata,
  input  logic          flush,
  output logic          sram_en,
  output logic [3:0]    sram_wen,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_IF   = 2'd1,
    PEND_DM   = 2'd2
  } pend_t;

  pend_t      pend;
  logic [3:0] starve_cnt;
  logic       fetch_force;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    fetch_force = if_req & (starve_cnt == STARVE_LIMIT);
    dm_gnt      = dm_req & ~fetch_force & ~reset;
    if_gnt      = if_req & ~flush & ~reset & (~dm_req | fetch_force);

    sram_en    = dm_gnt | if_gnt;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_wen   = 4'b0000;
    if (dm_gnt) begin
      sram_addr  = dm_addr;
      sram_wdata = dm_wdata;
      if (dm_wr) sram_wen = dm_be;
    end else if (if_gnt) begin
      sram_addr = if_addr;
    end

    // Reset gating drops a read that was in flight when reset arrived.
    if_rvalid = (pend == PEND_IF) & ~flush & ~reset;
    dm_rvalid = (pend == PEND_DM) & ~reset;
    if_rdata  = sram_rdata;
    dm_rdata  = sram_rdata;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
    if (reset) begin
      starve_cnt <= '0;
      pend       <= PEND_NONE;
    end else begin
      if (if_req & ~if_gnt & ~flush) begin
        if (starve_cnt != STARVE_LIMIT) starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= '0;
      end

      // Stores leave nothing to return.
      if (if_gnt)                pend <= PEND_IF;
      else if (dm_gnt & ~dm_wr)  pend <= PEND_DM;
      else                       pend <= PEND_NONE;
    end
  end

endmodule

// File: tb/tb_fairy_sram_arbiter.sv
// Random plus directed stimulus against a loss-streak model and a shadow memory;
// read returns are checked through a scoreboard queue by an independent monitor.
module tb_fairy_sram_arbiter;

  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned AW         = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic          dm_req;
  logic          dm_wr;
  logic [3:0]    dm_be;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [31:0]   dm_rdata;
  logic          flush;
  logic          sram_en;
  logic [3:0]    sram_wen;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;

  fairy_sram_arbiter #(.STARVE_MAX(STARVE_MAX), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .flush(flush),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] seed(input int i);
    return (i == 0) ? 32'hDEAD_BEEF : 32'h1357_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  // SRAM macro: 16 words indexed by address bits [5:2], one-cycle read latency.
  logic [31:0] mem [16];
  logic        mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 16; i++) mem[i] <= seed(i);
      mem_ready <= 1'b1;
    end else if (sram_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_wen[b]) mem[sram_addr[5:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
      sram_rdata <= mem[sram_addr[5:2]];
    end
  end

  // Reference state: shadow memory, fetch loss streak, expected returns.
  typedef struct {
    bit          is_if;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic [31:0] shadow [16];
  int          streak;
  int          cyc;
  exp_t        exp_q[$];
  int          n_pass;
  int          n_total;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_total++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, actual, expected);
  endtask

  task automatic step(input logic r, input logic ir, input logic [AW-1:0] ia,
                      input logic dr, input logic dw, input logic [3:0] be,
                      input logic [AW-1:0] da, input logic [31:0] wd, input logic fl);
    bit              win_if, win_dm, fetch_starved;
    logic [3:0]      e_wen;
    logic [AW-1:0]   e_addr;
    logic [31:0]     e_wdata;
    @(posedge clk);
    #1;
    reset = r; if_req = ir; if_addr = ia; dm_req = dr; dm_wr = dw;
    dm_be = be; dm_addr = da; dm_wdata = wd; flush = fl;
    cyc++;

    // A return due now is lost to reset, and a fetch return is lost to flush.
    if (exp_q.size() > 0 && exp_q[0].due == cyc && (r || (fl && exp_q[0].is_if)))
      void'(exp_q.pop_front());

    // Fetch that has already lost STARVE_MAX times in a row takes the slot.
    fetch_starved = ir && (streak == STARVE_MAX);
    win_dm = !r && dr && !fetch_starved;
    win_if = !r && ir && !fl && (!dr || fetch_starved);

    e_addr = '0; e_wdata = '0; e_wen = '0;
    if (win_dm) begin
      e_addr = da; e_wdata = wd;
      if (dw) begin
        e_wen = be;
        for (int b = 0; b < 4; b++) if (be[b]) shadow[da[5:2]][8*b +: 8] = wd[8*b +: 8];
      end else begin
        exp_q.push_back('{is_if: 1'b0, data: shadow[da[5:2]], due: cyc + 1});
      end
    end else if (win_if) begin
      e_addr = ia;
      exp_q.push_back('{is_if: 1'b1, data: shadow[ia[5:2]], due: cyc + 1});
    end

    if (r || !ir || fl || win_if) streak = 0;
    else if (streak < STARVE_MAX) streak++;

    @(negedge clk);
    check("if_gnt",     64'(if_gnt),     64'(win_if));
    check("dm_gnt",     64'(dm_gnt),     64'(win_dm));
    check("sram_en",    64'(sram_en),    64'(win_if || win_dm));
    check("sram_addr",  64'(sram_addr),  64'(e_addr));
    check("sram_wdata", 64'(sram_wdata), 64'(e_wdata));
    check("sram_wen",   64'(sram_wen),   64'(e_wen));
  endtask

  // Monitor: every presented return must match the oldest expectation, on time.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (if_rvalid || dm_rvalid) begin
        if (exp_q.size() == 0) begin
          check("spurious_rvalid", {62'd0, if_rvalid, dm_rvalid}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("rvalid_route", {62'd0, if_rvalid, dm_rvalid}, e.is_if ? 64'd2 : 64'd1);
          check("rdata", 64'(e.is_if ? if_rdata : dm_rdata), 64'(e.data));
          check("return_cycle", 64'(cyc), 64'(e.due));
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        check(e.is_if ? "missing_if_rvalid" : "missing_dm_rvalid", 64'd0, 64'd1);
      end
    end
  end

  initial begin
    logic [AW-1:0] ia, da;
    n_pass = 0; n_total = 0; cyc = 0; streak = 0;
    for (int i = 0; i < 16; i++) shadow[i] = seed(i);
    reset = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_wr = 1'b0;
    dm_be = '0; dm_addr = '0; dm_wdata = '0; flush = 1'b0;

    // Reset with both requesters asserted, then data wins on release.
    repeat (3) step(1, 1, 32'h40, 1, 0, 4'hF, 32'h08, 32'h0, 0);
    step(0, 1, 32'h40, 1, 0, 4'hF, 32'h08, 32'h0, 0);
    step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0);

    // Fetch read from 0x100 (word 0 holds 0xDEADBEEF), then an idle cycle.
    step(0, 1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0, 0);
    step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0);

    // Single-byte store, then read the word back through a load.
    step(0, 0, 32'h0, 1, 1, 4'b0100, 32'h204, 32'h5555_5555, 0);
    step(0, 0, 32'h0, 1, 0, 4'h0, 32'h204, 32'h0, 0);
    step(0, 0, 32'h0, 1, 1, 4'b0000, 32'h204, 32'hFFFF_FFFF, 0);
    step(0, 0, 32'h0, 1, 0, 4'h0, 32'h204, 32'h0, 0);

    // Continuous loads against continuous fetch: starvation forcing.
    for (int i = 0; i < 12; i++) step(0, 1, 32'h10, 1, 0, 4'h0, 32'(i * 4), 32'h0, 0);

    // Fetch granted, then flushed while its data returns.
    step(0, 1, 32'h14, 0, 0, 4'h0, 32'h0, 32'h0, 0);
    step(0, 1, 32'h18, 0, 0, 4'h0, 32'h0, 32'h0, 1);
    step(0, 1, 32'h18, 0, 0, 4'h0, 32'h0, 32'h0, 0);

    // Load granted, then reset before its return.
    step(0, 0, 32'h0, 1, 0, 4'h0, 32'h0C, 32'h0, 0);
    step(1, 0, 32'h0, 1, 0, 4'h0, 32'h0C, 32'h0, 0);
    step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      ia = {26'($urandom), $urandom_range(0, 15) == 0 ? 4'h0 : 4'($urandom), 2'b00};
      da = {26'($urandom), 4'($urandom), 2'b00};
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7, ia,
           $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4, 4'($urandom),
           da, $urandom, $urandom_range(0, 9) == 0);
    end

    repeat (3) step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
